obi_lsu_manager: RTL and testbench

//  OBI initiator (manager) driving the word-aligned 32-bit data memory from a core load/store port.

---
 rtl/obi_pkg.sv | 28 ++
 rtl/obi_lane_align.sv | 48 ++++
 rtl/obi_lsu_manager.sv | 180 ++++++++++++++++++
 tb/tb_obi_lsu_manager.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/obi_pkg.sv
// Shared types and byte-enable constants for the OBI load/store manager.
// Transfer sizes, FSM states, and a misalignment helper used by the optional error check.
package obi_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic misaligned(input size_e size, input logic [1:0] off);
    return ((size == SIZE_HALF) && off[0]) || ((size == SIZE_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/obi_lane_align.sv
// Byte-lane steering: store-side byte enables and lane replication, load-side extract and extend.
// Purely combinational; an undefined size yields all-zero outputs.
module obi_lane_align
  import obi_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] rshift;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rshift  = rdata_i >> {off_i, 3'b000};
    rbyte   = rshift[7:0];
    rhalf   = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;
    case (size_i)
      SIZE_BYTE: begin
        be_o    = BE_BYTE << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{rbyte[7] & ~unsigned_i}}, rbyte};
      end
      SIZE_HALF: begin
        // off[0] is ignored here; misalignment is policed (or not) by the manager
        be_o    = off_i[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{rhalf[15] & ~unsigned_i}}, rhalf};
      end
      SIZE_WORD: begin
        be_o    = BE_WORD;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/obi_lsu_manager.sv
// OBI manager for a core load/store port: one outstanding transfer, lane steering, response timeout.
// Define OBI_MISALIGN_ERR_EN to reject misaligned half/word accesses without issuing a request.
module obi_lsu_manager
  import obi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [1:0]            cmd_size_i,
  input  logic                  cmd_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]           cmd_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  obi_req_o,
  input  logic                  obi_gnt_i,
  output logic [ADDR_WIDTH-1:0] obi_addr_o,
  output logic                  obi_we_o,
  output logic [3:0]            obi_be_o,
  output logic [31:0]           obi_wdata_o,
  input  logic                  obi_rvalid_i,
  input  logic [31:0]           obi_rdata_i,
  input  logic                  obi_err_i
);

  localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit             TO_EN    = (TIMEOUT_CYCLES != 0);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  size_e                 size_q, size_d;
  logic [1:0]            off_q, off_d;
  logic                  uns_q, uns_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  size_e       cmd_size;
  size_e       al_size;
  logic [1:0]  al_off;
  logic        al_uns;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        cmd_bad;

  assign cmd_size = size_e'(cmd_size_i);

  // One aligner serves both directions: command fields while idle, captured fields afterwards
  assign al_size = (state_q == ST_IDLE) ? cmd_size : size_q;
  assign al_off  = (state_q == ST_IDLE) ? cmd_addr_i[1:0] : off_q;
  assign al_uns  = (state_q == ST_IDLE) ? cmd_unsigned_i : uns_q;

  obi_lane_align u_align (
    .size_i     (al_size),
    .off_i      (al_off),
    .unsigned_i (al_uns),
    .wdata_i    (cmd_wdata_i),
    .rdata_i    (obi_rdata_i),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata)
  );

`ifdef OBI_MISALIGN_ERR_EN
  assign cmd_bad = (cmd_size == SIZE_BAD) || misaligned(cmd_size, cmd_addr_i[1:0]);
`else
  assign cmd_bad = (cmd_size == SIZE_BAD);
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    off_d       = off_q;
    uns_d       = uns_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    cmd_ready_o = 1'b0;
    obi_req_o   = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          if (cmd_bad) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            addr_d  = cmd_addr_i;
            we_d    = cmd_we_i;
            be_d    = al_be;
            wdata_d = al_wdata;
            size_d  = cmd_size;
            off_d   = cmd_addr_i[1:0];
            uns_d   = cmd_unsigned_i;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        obi_req_o = 1'b1;
        if (obi_gnt_i) begin
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response landing on the terminal cycle still wins over the timeout
        if (obi_rvalid_i) begin
          err_d   = obi_err_i;
          rdata_d = (obi_err_i || we_q) ? '0 : al_rdata;
          state_d = ST_RESP;
        end else if (TO_EN && (cnt_q == '0)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= SIZE_BYTE;
      off_q   <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      off_q   <= off_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign obi_addr_o  = addr_q;
  assign obi_we_o    = we_q;
  assign obi_be_o    = be_q;
  assign obi_wdata_o = wdata_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_obi_lsu_manager.sv
// Bench for obi_lsu_manager: directed vector table, reset/late-response sequences, random traffic vs. a reference model.
module tb_obi_lsu_manager;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i, cmd_unsigned_i;
  logic [1:0]  cmd_size_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        obi_req_o, obi_gnt_i, obi_we_o, obi_rvalid_i, obi_err_i;
  logic [31:0] obi_addr_o, obi_wdata_o, obi_rdata_i;
  logic [3:0]  obi_be_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  obi_lsu_manager #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_size_i(cmd_size_i), .cmd_unsigned_i(cmd_unsigned_i), .cmd_addr_i(cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i),
    .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o), .obi_be_o(obi_be_o),
    .obi_wdata_o(obi_wdata_o), .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
    .obi_err_i(obi_err_i)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gnt_dly;   // REQ cycles with gnt low before the grant
    int          rv_dly;    // WAIT cycle (1-based) carrying rvalid; 0 = never
    logic [31:0] rdata;
    logic        berr;
    logic [3:0]  be;
    logic [31:0] owdata;
    logic [31:0] rsp;
    logic        err;
    int          lat;       // cycles from command accept to rsp_valid
    int          reqc;      // cycles with obi_req_o high
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour from the transfer rules: byte counts, shifts and two's-complement arithmetic
  function automatic vec_t expect_of(input vec_t v);
    int     n, off;
    logic   bad;
    longint val;
    bad = (v.size == 2'd3);
`ifdef OBI_MISALIGN_ERR_EN
    if (v.size == 2'd1 && v.addr[0]) bad = 1'b1;
    if (v.size == 2'd2 && v.addr[1:0] != 2'b00) bad = 1'b1;
`endif
    v.be = '0; v.owdata = '0; v.rsp = '0;
    if (bad) begin
      v.err = 1'b1; v.lat = 1; v.reqc = 0;
      return v;
    end
    n   = 1 << v.size;
    off = (v.size == 2'd0) ? int'(v.addr[1:0]) : (v.size == 2'd1) ? 2 * int'(v.addr[1]) : 0;
    v.be = 4'(((1 << n) - 1) << off);
    for (int i = 0; i < 4; i++) v.owdata[8*i +: 8] = v.wdata[8*(i % n) +: 8];
    v.reqc = v.gnt_dly + 1;
    if (v.rv_dly < 1 || v.rv_dly > T) begin
      v.err = 1'b1;
      v.lat = 1 + v.gnt_dly + T + 1;
    end else begin
      v.err = v.berr;
      v.lat = 1 + v.gnt_dly + v.rv_dly + 1;
      if (!v.berr && !v.we) begin
        val = (64'(v.rdata) >> (8 * off)) & ((64'd1 << (8 * n)) - 1);
        if (!v.uns && val >= (64'd1 << (8 * n - 1))) val = val - (64'd1 << (8 * n));
        v.rsp = val[31:0];
      end
    end
    return v;
  endfunction

  task automatic run(input vec_t e, input bit noise);
    int          cyc, k, j, reqc;
    bit          phase, done, unstable;
    logic [31:0] a0, w0, rd;
    logic [3:0]  b0;
    logic        we0, er;
    cyc = 0; k = 0; j = 0; reqc = 0; phase = 0; done = 0; unstable = 0;
    a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0; rd = '0; er = 1'b0;
    chk("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1; cmd_we_i = e.we; cmd_size_i = e.size; cmd_unsigned_i = e.uns;
    cmd_addr_i = e.addr; cmd_wdata_i = e.wdata;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    while (!done && cyc < 40) begin
      cyc++;
      obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_err_i = 1'b0;
      if (rsp_valid_o) begin
        done = 1; rd = rsp_rdata_o; er = rsp_err_o;
      end else if (obi_req_o) begin
        reqc++;
        if (k == 0) begin
          a0 = obi_addr_o; w0 = obi_wdata_o; b0 = obi_be_o; we0 = obi_we_o;
        end else if (a0 !== obi_addr_o || w0 !== obi_wdata_o || b0 !== obi_be_o || we0 !== obi_we_o) begin
          unstable = 1;
        end
        if (noise) begin
          obi_rvalid_i = 1'($urandom_range(0, 1)); obi_rdata_i = $urandom; obi_err_i = 1'($urandom_range(0, 1));
        end
        if (!phase && k == e.gnt_dly) begin
          obi_gnt_i = 1'b1; phase = 1;
        end
        k++;
      end else if (phase) begin
        j++;
        if (j == e.rv_dly) begin
          obi_rvalid_i = 1'b1; obi_rdata_i = e.rdata; obi_err_i = e.berr;
        end
      end
      @(negedge clk);
    end
    obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_err_i = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_wait_budget: no rsp_valid within 40 cycles (addr %h)", e.addr);
    end
    chk("rsp_latency", 32'(cyc), 32'(e.lat));
    chk("rsp_rdata", rd, e.rsp);
    chk("rsp_err", 32'(er), 32'(e.err));
    chk("req_cycles", 32'(reqc), 32'(e.reqc));
    if (e.reqc > 0) begin
      chk("obi_be", 32'(b0), 32'(e.be));
      chk("obi_wdata", w0, e.owdata);
      chk("obi_addr", a0, e.addr);
      chk("obi_we", 32'(we0), 32'(e.we));
      chk("req_stable", 32'(unstable), 32'd0);
    end
    chk("rsp_single_pulse", 32'(rsp_valid_o), 32'd0);
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    tbl[0] = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1, 32'h0, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 3, 1};
    tbl[1] = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, 1, 32'h80FF0000, 1'b0, 4'h8, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1};
    tbl[2] = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, 1, 32'h80FF0000, 1'b0, 4'h8, 32'h0, 32'h00000080, 1'b0, 3, 1};
    tbl[3] = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h0000A5A5, 5, 1, 32'h0, 1'b0, 4'hC, 32'hA5A5A5A5, 32'h0, 1'b0, 8, 6};
`ifdef OBI_MISALIGN_ERR_EN
    tbl[4] = '{1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 0, 2, 32'h12348001, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 0};
`else
    tbl[4] = '{1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 0, 2, 32'h12348001, 1'b0, 4'h3, 32'h0, 32'hFFFF8001, 1'b0, 4, 1};
`endif
    tbl[5] = '{1'b0, 2'd3, 1'b0, 32'h30, 32'h55, 0, 1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 0};
    tbl[6] = '{1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 1, 1, 32'hCAFEF00D, 1'b1, 4'hF, 32'h0, 32'h0, 1'b1, 4, 2};
    tbl[7] = '{1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 0, 3, 32'hBEEF1234, 1'b0, 4'hC, 32'h0, 32'h0000BEEF, 1'b0, 5, 1};
    tbl[8] = '{1'b1, 2'd0, 1'b0, 32'h01, 32'h123456C3, 2, 4, 32'h0, 1'b0, 4'h2, 32'hC3C3C3C3, 32'h0, 1'b0, 8, 3};
    tbl[9] = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, 0, 32'h0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 6, 1};

    reset = 1'b1;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_size_i = 2'd0; cmd_unsigned_i = 1'b0;
    cmd_addr_i = '0; cmd_wdata_i = '0;
    obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = '0; obi_err_i = 1'b0;
    #23;
    chk("reset_obi_req", 32'(obi_req_o), 32'd0);
    chk("reset_obi_be", 32'(obi_be_o), 32'd0);
    chk("reset_obi_addr", obi_addr_o, 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err_o), 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready_o), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run(tbl[i], 1'b0);

    // Late response after the timeout must be ignored while idle
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'h11223344; obi_err_i = 1'b1;
    @(negedge clk);
    obi_rvalid_i = 1'b0; obi_err_i = 1'b0;
    chk("late_rvalid_no_rsp", 32'(rsp_valid_o), 32'd0);
    chk("late_rvalid_idle", 32'(cmd_ready_o), 32'd1);
    chk("late_rvalid_err_held", 32'(rsp_err_o), 32'd1);
    run(tbl[0], 1'b0);

    // Reset while requesting drops obi_req_o immediately
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_size_i = 2'd2; cmd_addr_i = 32'h40;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("req_before_reset", 32'(obi_req_o), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("reset_mid_req_drop", 32'(obi_req_o), 32'd0);
    chk("reset_mid_addr", obi_addr_o, 32'd0);
    chk("reset_mid_ready", 32'(cmd_ready_o), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_no_rsp", 32'(rsp_valid_o), 32'd0);
      chk("post_reset_no_req", 32'(obi_req_o), 32'd0);
    end
    obi_rvalid_i = 1'b0;
    chk("post_reset_ready", 32'(cmd_ready_o), 32'd1);

    for (int i = 0; i < 200; i++) begin
      rv.we      = 1'($urandom_range(0, 1));
      rv.size    = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rv.uns     = 1'($urandom_range(0, 1));
      rv.addr    = $urandom;
      rv.wdata   = $urandom;
      rv.gnt_dly = $urandom_range(0, 3);
      rv.rv_dly  = $urandom_range(1, 6);
      rv.rdata   = $urandom;
      rv.berr    = ($urandom_range(0, 7) == 0);
      run(expect_of(rv), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
